// File: rtl/fetch_sequencer_if.sv
// Fetch-stage bus: instruction-memory port, redirect request and decode handshake.
// The master modport is the fetch sequencer; the slave side is memory plus decode.
interface fetch_sequencer_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        halted;
  logic        fault;

  modport master (
    output imem_addr, instr_valid, instr, instr_pc, halted, fault,
    input  imem_data, redirect, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_addr, instr_valid, instr, instr_pc, halted, fault,
    output imem_data, redirect, redirect_pc, instr_ready
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Program-counter owner and instruction prefetcher: one fetch per cycle into a
// 2-entry buffer, with redirect/flush, halt-opcode stop and misaligned-target fault.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
  input  logic               clk,
  input  logic               rst_n,
  fetch_sequencer_if.master  bus
);

  typedef enum logic [1:0] {RUN, HALTED, FAULT} state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [1:0]        cnt_q, cnt_d;
  entry_t [1:0]      slot_q, slot_d;

  logic              valid;
  logic              pop;
  logic              push;
  logic              space;
  logic              halt_hit;
  logic [1:0]        base;

  assign valid    = (cnt_q != 2'd0) && (state_q != FAULT);
  assign pop      = valid && bus.instr_ready;
  assign space    = (cnt_q != 2'd2) || pop;
  assign halt_hit = (bus.imem_data[31:26] == HALT_OPCODE);
  // Slot index the incoming word lands in once this cycle's pop has shifted the FIFO.
  assign base     = cnt_q - {1'b0, pop};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    slot_d  = slot_q;
    push    = 1'b0;

    if (pop) slot_d[0] = slot_q[1];

    if ((state_q != FAULT) && bus.redirect) begin
      cnt_d = 2'd0;
      if (bus.redirect_pc[1:0] == 2'b00) begin
        pc_d    = bus.redirect_pc;
        state_d = RUN;
      end else begin
        state_d = FAULT;
      end
    end else begin
      if ((state_q == RUN) && space) begin
        if (halt_hit) state_d = HALTED;
        else          push    = 1'b1;
      end
      if (push) begin
        slot_d[base[0]] = entry_t'{pc: pc_q, word: bus.imem_data};
        pc_d            = pc_q + 32'd4;
      end
      cnt_d = base + {1'b0, push};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      cnt_q   <= 2'd0;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = valid;
  assign bus.instr       = slot_q[0].word;
  assign bus.instr_pc    = slot_q[0].pc;
  assign bus.halted      = (state_q == HALTED);
  assign bus.fault       = (state_q == FAULT);

endmodule
